// File: rtl/bhg_mixer_i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bhg_audio_pkg
//  Description : Shared types, FSM encodings and configuration helpers for the
//                mixer-side I2S transmitter.
//  Revision    : 1.0
// ============================================================================
package bhg_audio_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [0:0] c_st_idle = ST_IDLE;
    localparam logic [0:0] c_st_run  = ST_RUN;

    // Frame length in clk cycles: two slots of SLOT_BITS bit clocks each.
    function automatic int frame_len(input int slot_bits, input int bclk_div);
        return 2 * slot_bits * bclk_div;
    endfunction

    // LRCK is high from the last bit of the left slot to the second-to-last
    // bit of the right slot, so it leads each slot MSB by one BCLK.
    function automatic int lrck_lo(input int slot_bits);
        return slot_bits - 1;
    endfunction

    function automatic int lrck_hi(input int slot_bits);
        return 2 * slot_bits - 2;
    endfunction

    function automatic bit cfg_ok(input int in_bits, input int slot_bits,
                                  input int bclk_div);
        return (in_bits >= 2) && (in_bits <= slot_bits) &&
               (slot_bits >= 16) && (slot_bits <= 32) &&
               (bclk_div >= 4) && ((bclk_div % 2) == 0) &&
               (frame_len(slot_bits, bclk_div) >= 32);
    endfunction

    localparam int c_dflt_frame_len = frame_len(16, 32);
    localparam int c_dflt_lrck_lo   = lrck_lo(16);
    localparam int c_dflt_lrck_hi   = lrck_hi(16);

endpackage
`default_nettype wire

// File: rtl/bhg_mixer_i2s_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bhg_mixer_i2s_tx_if
//  Description : Sample-side controls and I2S serial outputs of the transmitter.
//  Revision    : 1.0
// ============================================================================
interface bhg_mixer_i2s_tx_if #(
    parameter int IN_BITS = 12
);
    logic                      en;
    logic                      mute;
    logic signed [IN_BITS-1:0] s_in;
    logic                      sample_req;
    logic                      busy;
    logic                      i2s_bclk;
    logic                      i2s_lrck;
    logic                      i2s_sdata;

    modport master (
        output en, mute, s_in,
        input  sample_req, busy, i2s_bclk, i2s_lrck, i2s_sdata
    );

    modport slave (
        input  en, mute, s_in,
        output sample_req, busy, i2s_bclk, i2s_lrck, i2s_sdata
    );
endinterface
`default_nettype wire

// File: rtl/bhg_mixer_i2s_tx_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : bhg_i2s_clkgen
//  Description : Bit/frame counters, registered BCLK and LRCK, frame strobes.
//  Revision    : 1.0
// ============================================================================
module bhg_i2s_clkgen
    import bhg_audio_pkg::*;
#(
    parameter int SLOT_BITS = 16,
    parameter int BCLK_DIV  = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    output logic      o_bclk,
    output logic      o_lrck,
    output logic      o_frame_start,
    output logic      o_frame_end,
    output logic      o_shift
);

    localparam int c_div_w = $clog2(BCLK_DIV);
    localparam int c_bits  = 2 * SLOT_BITS;
    localparam int c_bit_w = $clog2(c_bits);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(BCLK_DIV / 2);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_bits - 1);
    localparam logic [c_bit_w-1:0] c_lr_lo    = c_bit_w'(lrck_lo(SLOT_BITS));
    localparam logic [c_bit_w-1:0] c_lr_hi    = c_bit_w'(lrck_hi(SLOT_BITS));

    logic [c_div_w-1:0] r_div_cnt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic               r_bclk;
    logic               r_lrck;
    logic               w_div_wrap;

    assign w_div_wrap = (r_div_cnt == c_div_last);

    // Counters sit at zero whenever the transmitter is not running, so the
    // first running cycle is always a frame start.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap) begin
                r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered one cycle behind the counters they decode; the
    // shift register in the top carries the same lag, keeping all pins aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk <= 1'b0;
            r_lrck <= 1'b0;
        end else begin
            r_bclk <= i_run && (r_div_cnt >= c_div_half);
            r_lrck <= i_run && (r_bit_cnt >= c_lr_lo) && (r_bit_cnt <= c_lr_hi);
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrck        = r_lrck;
    assign o_frame_start = i_run && (r_div_cnt == '0) && (r_bit_cnt == '0);
    assign o_frame_end   = i_run && w_div_wrap && (r_bit_cnt == c_bit_last);
    assign o_shift       = i_run && (r_div_cnt == '0) && (r_bit_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/bhg_mixer_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bhg_mixer_i2s_tx
//  Description : Mixer-facing I2S transmitter; strobes the mixer once per frame
//                and sends its mono sample in both stereo slots.
//  Revision    : 1.0
// ============================================================================
module bhg_mixer_i2s_tx
    import bhg_audio_pkg::*;
#(
    parameter int IN_BITS   = 12,
    parameter int SLOT_BITS = 16,
    parameter int BCLK_DIV  = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bhg_mixer_i2s_tx_if.slave     bus
);

    localparam int c_pad    = SLOT_BITS - IN_BITS;
    localparam int c_sr_len = 2 * SLOT_BITS;

    if (!cfg_ok(IN_BITS, SLOT_BITS, BCLK_DIV)) begin : g_bad_cfg
        $error("bhg_mixer_i2s_tx: illegal IN_BITS/SLOT_BITS/BCLK_DIV combination");
    end

    logic [0:0]           r_state;
    logic [c_sr_len-1:0]  r_sr;
    logic                 r_req;
    logic                 r_busy;
    logic                 w_run;
    logic                 w_frame_start;
    logic                 w_frame_end;
    logic                 w_shift;
    logic                 w_bclk;
    logic                 w_lrck;
    logic [SLOT_BITS-1:0] w_word;

    // An idle block with en high starts a frame in that very cycle.
    assign w_run  = (r_state == c_st_run) || bus.en;
    assign w_word = bus.mute ? '0 : (SLOT_BITS'(bus.s_in) << c_pad);

    bhg_i2s_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .i_run         (w_run),
        .o_bclk        (w_bclk),
        .o_lrck        (w_lrck),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end),
        .o_shift       (w_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (bus.en) r_state <= c_st_run;
                c_st_run:  if (w_frame_end && !bus.en) r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // The shift register MSB is the serial pin; clearing it when not running
    // keeps sdata low in idle without a separate output flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_req  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_req  <= w_frame_start;
            r_busy <= w_run;
            if (!w_run) begin
                r_sr <= '0;
            end else if (w_frame_start) begin
                r_sr <= {w_word, w_word};
            end else if (w_shift) begin
                r_sr <= r_sr << 1;
            end
        end
    end

    assign bus.sample_req = r_req;
    assign bus.busy       = r_busy;
    assign bus.i2s_bclk   = w_bclk;
    assign bus.i2s_lrck   = w_lrck;
    assign bus.i2s_sdata  = r_sr[c_sr_len-1];

endmodule
`default_nettype wire

// File: tb/tb_bhg_mixer_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bhg_mixer_i2s_tx
//  Description : Directed self-checking bench for bhg_mixer_i2s_tx (F = 128).
//  Revision    : 1.0
// ============================================================================
module tb_bhg_mixer_i2s_tx;

    localparam int c_in_bits   = 12;
    localparam int c_slot_bits = 16;
    localparam int c_bclk_div  = 4;
    localparam int c_frame     = 2 * c_slot_bits * c_bclk_div;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    bhg_mixer_i2s_tx_if #(.IN_BITS(c_in_bits)) bus ();

    bhg_mixer_i2s_tx #(
        .IN_BITS   (c_in_bits),
        .SLOT_BITS (c_slot_bits),
        .BCLK_DIV  (c_bclk_div)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, bus.sample_req, bus.busy, bus.i2s_bclk,
                bus.i2s_lrck, bus.i2s_sdata};
    endfunction

    task automatic next_frame(input string tag);
        step();
        check_val(tag, {31'd0, bus.sample_req}, 32'd1);
    endtask

    // Called on frame cycle 0; returns on cycle 127. Bits are taken at the
    // BCLK rising edge (third cycle of each bit period).
    task automatic read_frame(input string tag, input logic [31:0] exp_word,
                              input int chg_k, input logic [11:0] chg_val,
                              input int en_off_k, input int en_on_k);
        logic [31:0] data;
        logic [31:0] lr;
        int          bclk_err;
        int          busy_err;
        int          req_err;
        int          glitch;
        logic        prev_sd;
        data = '0;
        lr = '0;
        bclk_err = 0;
        busy_err = 0;
        req_err = 0;
        glitch = 0;
        prev_sd = bus.i2s_sdata;
        for (int k = 0; k < c_frame; k++) begin
            if (k > 0) step();
            if (bus.i2s_bclk !== ((k % 4) >= 2)) bclk_err++;
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.sample_req !== (k == 0)) req_err++;
            if ((k % 4) != 0 && bus.i2s_sdata !== prev_sd) glitch++;
            prev_sd = bus.i2s_sdata;
            if ((k % 4) == 2) begin
                data = {data[30:0], bus.i2s_sdata};
                lr   = {lr[30:0], bus.i2s_lrck};
            end
            if (k == chg_k) bus.s_in = chg_val;
            if (k == en_off_k) bus.en = 1'b0;
            if (k == en_on_k) bus.en = 1'b1;
        end
        check_val({tag, "_word"}, data, exp_word);
        check_val({tag, "_lrck"}, lr, 32'h0001_FFFE);
        check_val({tag, "_bclk_err"}, 32'(bclk_err), 32'd0);
        check_val({tag, "_busy_err"}, 32'(busy_err), 32'd0);
        check_val({tag, "_req_err"}, 32'(req_err), 32'd0);
        check_val({tag, "_sdata_glitch"}, 32'(glitch), 32'd0);
    endtask

    initial begin
        int quiet_err;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.mute = 1'b0;
        bus.s_in = 12'h7FF;

        repeat (3) begin
            step();
            check_val("reset_outs", outs(), 32'd0);
        end
        rst = 1'b0;
        step();
        check_val("first_req", {31'd0, bus.sample_req}, 32'd1);
        check_val("first_busy", {31'd0, bus.busy}, 32'd1);
        read_frame("f1_7ff", 32'h7FF0_7FF0, -1, 12'h000, -1, -1);

        bus.s_in = 12'h800;
        next_frame("f2_req_period");
        read_frame("f2_800", 32'h8000_8000, 40, 12'h001, -1, -1);
        next_frame("f3_req_period");
        read_frame("f3_001", 32'h0010_0010, -1, 12'h000, -1, -1);

        bus.s_in = 12'h5A5;
        bus.mute = 1'b1;
        next_frame("f4_req_period");
        read_frame("f4_mute", 32'h0000_0000, -1, 12'h000, -1, -1);
        bus.mute = 1'b0;
        next_frame("f5_req_period");
        read_frame("f5_5a5", 32'h5A50_5A50, -1, 12'h000, 20, -1);

        step();
        check_val("idle_after_tail", outs(), 32'd0);
        quiet_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (outs() !== 32'd0) quiet_err++;
        end
        check_val("idle_quiet", 32'(quiet_err), 32'd0);

        bus.s_in = 12'h123;
        bus.en = 1'b1;
        step();
        check_val("restart_req", {31'd0, bus.sample_req}, 32'd1);
        read_frame("f6_123", 32'h1230_1230, -1, 12'h000, 60, 100);
        next_frame("f7_continuous_req");

        for (int i = 0; i < 80; i++) step();
        check_val("f7_lrck_bit20", {31'd0, bus.i2s_lrck}, 32'd1);
        rst = 1'b1;
        bus.s_in = 12'hABC;
        step();
        check_val("rst_abort_outs", outs(), 32'd0);
        step();
        check_val("rst_hold_outs", outs(), 32'd0);
        rst = 1'b0;
        step();
        check_val("post_rst_req", {31'd0, bus.sample_req}, 32'd1);
        read_frame("f8_abc", 32'hABC0_ABC0, -1, 12'h000, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
